// File: rtl/clock_gating_ctrl_if.sv
// Control and status bundle for the multi-channel clock-gating controller.
// The master side is the power-control logic; the slave side is the controller itself.
interface clock_gating_ctrl_if #(
    parameter int NUM_CH = 4
);
    localparam int CNT_W = $clog2(NUM_CH + 1);

    logic [NUM_CH-1:0] i_en;
    logic [NUM_CH-1:0] i_busy;
    logic              i_test_en;
    logic [NUM_CH-1:0] o_clk;
    logic [NUM_CH-1:0] o_clk_on;
    logic [NUM_CH-1:0] o_sleep;
    logic [CNT_W-1:0]  o_active_cnt;

    modport master (
        output i_en,
        output i_busy,
        output i_test_en,
        input  o_clk,
        input  o_clk_on,
        input  o_sleep,
        input  o_active_cnt
    );

    modport slave (
        input  i_en,
        input  i_busy,
        input  i_test_en,
        output o_clk,
        output o_clk_on,
        output o_sleep,
        output o_active_cnt
    );
endinterface

// File: rtl/clock_gating_ctrl.sv
// Multi-channel clock-gating controller: per-channel OFF/RUN/DRAIN/SLEEP state machine
// with idle-driven sleep, plus a low-phase latch gating cell per channel.
module clock_gating_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_CYC = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    clock_gating_ctrl_if.slave bus
);
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    localparam int CNT_W  = $clog2(NUM_CH + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_RUN,
        S_DRAIN,
        S_SLEEP
    } state_t;

    state_t            state    [NUM_CH];
    logic [IDLE_W-1:0] idle_cnt [NUM_CH];
    logic [NUM_CH-1:0] clk_on_q;
    logic [NUM_CH-1:0] sleep_q;
    logic [NUM_CH-1:0] en_lat;
    logic [CNT_W-1:0]  active_cnt;

    // NOTE: sequential state uses non-blocking assignments so every channel sees pre-edge values.
    always_ff @(posedge i_clk) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (i_reset || (state[ch] != S_OFF && !bus.i_en[ch])) begin
                state[ch]    <= S_OFF;
                idle_cnt[ch] <= '0;
                clk_on_q[ch] <= 1'b0;
                sleep_q[ch]  <= 1'b0;
            end else begin
                case (state[ch])
                    S_OFF: begin
                        if (bus.i_en[ch]) begin
                            state[ch]    <= S_RUN;
                            clk_on_q[ch] <= 1'b1;
                            sleep_q[ch]  <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (!bus.i_busy[ch]) begin
                            state[ch]    <= S_DRAIN;
                            idle_cnt[ch] <= '0;
                        end
                    end
                    S_DRAIN: begin
                        if (bus.i_busy[ch]) begin
                            state[ch]    <= S_RUN;
                            idle_cnt[ch] <= '0;
                        end else if (idle_cnt[ch] == IDLE_LAST) begin
                            state[ch]    <= S_SLEEP;
                            clk_on_q[ch] <= 1'b0;
                            sleep_q[ch]  <= 1'b1;
                        end else begin
                            idle_cnt[ch] <= idle_cnt[ch] + IDLE_W'(1);
                        end
                    end
                    S_SLEEP: begin
                        // Wake costs one cycle: the pulse at the wake edge is still gated.
                        if (bus.i_busy[ch]) begin
                            state[ch]    <= S_RUN;
                            clk_on_q[ch] <= 1'b1;
                            sleep_q[ch]  <= 1'b0;
                        end
                    end
                    default: begin
                        state[ch] <= S_OFF;
                    end
                endcase
            end
        end
    end

    // NOTE: this latch is intentional; it only opens while i_clk is low, so an enable
    // change can never clip or extend a high phase of the gated clock.
    always_latch begin
        if (!i_clk) begin
            en_lat <= clk_on_q | {NUM_CH{bus.i_test_en}};
        end
    end

    assign bus.o_clk = {NUM_CH{i_clk}} & en_lat;

    // NOTE: combinational logic uses blocking assignments with a default first, so no latch is inferred.
    always_comb begin
        active_cnt = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            active_cnt = active_cnt + CNT_W'(clk_on_q[ch]);
        end
    end

    assign bus.o_clk_on     = clk_on_q;
    assign bus.o_sleep      = sleep_q;
    assign bus.o_active_cnt = active_cnt;
endmodule

// File: tb/tb_clock_gating_ctrl.sv
// Self-checking bench for clock_gating_ctrl: directed scenarios plus randomized traffic,
// compared against an idle-run-length model of each channel.
module tb_clock_gating_ctrl;
    localparam int NUM_CH   = 4;
    localparam int IDLE_CYC = 4;

    logic clk = 1'b0;
    logic rst;

    clock_gating_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    clock_gating_ctrl #(
        .NUM_CH  (NUM_CH),
        .IDLE_CYC(IDLE_CYC)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a channel is either disabled, or enabled and awake/asleep.
    // m_idle counts consecutive idle samples since the channel last saw activity.
    bit m_en    [NUM_CH];
    bit m_sleep [NUM_CH];
    int m_idle  [NUM_CH];

    logic [NUM_CH-1:0] exp_gate;
    logic [NUM_CH-1:0] hi_a, hi_b, lo;

    function automatic logic [NUM_CH-1:0] m_on();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_en[c] && !m_sleep[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] m_sl();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_en[c] && m_sleep[c];
        return v;
    endfunction

    function automatic logic [2:0] m_cnt();
        int n = 0;
        for (int c = 0; c < NUM_CH; c++) n += (m_en[c] && !m_sleep[c]) ? 1 : 0;
        return 3'(n);
    endfunction

    function automatic void model_update();
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst || !bus.i_en[c]) begin
                m_en[c] = 0; m_sleep[c] = 0; m_idle[c] = 0;
            end else if (!m_en[c]) begin
                m_en[c] = 1; m_sleep[c] = 0; m_idle[c] = 0;
            end else if (m_sleep[c]) begin
                if (bus.i_busy[c]) begin
                    m_sleep[c] = 0; m_idle[c] = 0;
                end
            end else if (bus.i_busy[c]) begin
                m_idle[c] = 0;
            end else begin
                m_idle[c]++;
                if (m_idle[c] == IDLE_CYC + 1) m_sleep[c] = 1;
            end
        end
    endfunction

    // One clock cycle: gated-clock expectation is fixed by what the latch saw in the low phase.
    task automatic step();
        exp_gate = m_on() | {NUM_CH{bus.i_test_en}};
        @(posedge clk);
        model_update();
        #1 hi_a = bus.o_clk;
        #3 hi_b = bus.o_clk;
        @(negedge clk);
        #1 lo = bus.o_clk;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.i_en = '1; bus.i_busy = '1; bus.i_test_en = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ((hi_a | hi_b | lo) !== 4'h0) begin
                bad++; $display("FAIL reset_clk: got %h required 0", hi_a | hi_b | lo);
            end
            total++;
            if (bus.o_clk_on !== 4'h0 || bus.o_sleep !== 4'h0 || bus.o_active_cnt !== 3'd0) begin
                bad++; $display("FAIL reset_status: clk_on=%h sleep=%h cnt=%0d required 0/0/0",
                                bus.o_clk_on, bus.o_sleep, bus.o_active_cnt);
            end
        end
        rst = 1'b0;
        step();
        total++;
        if (bus.o_clk_on !== 4'hF || bus.o_active_cnt !== 3'd4) begin
            bad++; $display("FAIL reset_release: clk_on=%h cnt=%0d required F/4",
                            bus.o_clk_on, bus.o_active_cnt);
        end
    endtask

    task automatic test_enable_disable();
        int p0 = 0, po = 0, runts = 0;
        bus.i_en = '0; bus.i_busy = '0;
        step(); step();
        bus.i_en = 4'b0001; bus.i_busy = 4'b0001;
        for (int i = 0; i < 13; i++) begin
            if (i == 10) bus.i_en = '0;
            step();
            p0 += int'(hi_a[0]);
            po += int'(|hi_a[3:1]);
            runts += int'(hi_a !== hi_b) + int'(lo !== 4'h0);
        end
        total++;
        if (p0 != 10) begin bad++; $display("FAIL en_dis_pulses: got %0d required 10", p0); end
        total++;
        if (po != 0) begin bad++; $display("FAIL en_dis_others: got %0d required 0", po); end
        total++;
        if (runts != 0) begin bad++; $display("FAIL en_dis_runt: got %0d required 0", runts); end
        total++;
        if (hi_a[0] !== 1'b0) begin bad++; $display("FAIL en_dis_final: got %b required 0", hi_a[0]); end
    endtask

    task automatic test_idle_gating();
        bus.i_en = 4'b0010; bus.i_busy = 4'b0010;
        step(); step();
        bus.i_busy = '0;
        for (int i = 1; i <= 5; i++) begin
            step();
            total++;
            if (bus.o_sleep[1] !== (i == 5) || bus.o_sleep !== m_sl()) begin
                bad++; $display("FAIL idle_sleep_%0d: got %h required %h", i, bus.o_sleep, m_sl());
            end
        end
        step();
        total++;
        if (hi_a[1] !== 1'b0) begin bad++; $display("FAIL idle_stopped: got %b required 0", hi_a[1]); end
        bus.i_busy = 4'b0010;
        step();
        total++;
        if (bus.o_sleep[1] !== 1'b0 || hi_a[1] !== 1'b0) begin
            bad++; $display("FAIL wake_edge: sleep=%b clk=%b required 0/0", bus.o_sleep[1], hi_a[1]);
        end
        step();
        total++;
        if (hi_a[1] !== 1'b1) begin bad++; $display("FAIL wake_resume: got %b required 1", hi_a[1]); end
        for (int r = 0; r < 2; r++) begin
            bus.i_busy = '0;
            for (int i = 0; i < 3; i++) begin
                step();
                total++;
                if (bus.o_sleep[1] !== 1'b0 || bus.o_clk_on[1] !== 1'b1) begin
                    bad++; $display("FAIL short_idle: sleep=%b clk_on=%b required 0/1",
                                    bus.o_sleep[1], bus.o_clk_on[1]);
                end
            end
            bus.i_busy = 4'b0010;
            step();
        end
    endtask

    task automatic test_priority();
        bus.i_en = 4'b0100; bus.i_busy = '0;
        for (int i = 0; i < 7; i++) step();
        total++;
        if (bus.o_sleep[2] !== 1'b1) begin bad++; $display("FAIL prio_asleep: got %b required 1", bus.o_sleep[2]); end
        bus.i_en = '0; bus.i_busy = 4'b0100;
        step();
        total++;
        if (bus.o_clk_on[2] !== 1'b0 || bus.o_sleep[2] !== 1'b0) begin
            bad++; $display("FAIL prio_off: clk_on=%b sleep=%b required 0/0", bus.o_clk_on[2], bus.o_sleep[2]);
        end
        step();
        total++;
        if (hi_a[2] !== 1'b0 || bus.o_clk_on !== m_on()) begin
            bad++; $display("FAIL prio_clk: clk=%b clk_on=%h required 0/%h", hi_a[2], bus.o_clk_on, m_on());
        end
    endtask

    task automatic test_override();
        bus.i_en = '0; bus.i_busy = '0;
        step(); step();
        bus.i_test_en = 1'b1;
        step();
        total++;
        if (hi_a !== 4'hF || hi_b !== 4'hF || lo !== 4'h0) begin
            bad++; $display("FAIL override_on: hi=%h/%h lo=%h required F/F/0", hi_a, hi_b, lo);
        end
        total++;
        if (bus.o_clk_on !== 4'h0 || bus.o_active_cnt !== 3'd0) begin
            bad++; $display("FAIL override_status: clk_on=%h cnt=%0d required 0/0", bus.o_clk_on, bus.o_active_cnt);
        end
        // Dropping the override mid-pulse must not clip the pulse already running.
        @(posedge clk); model_update();
        #1 hi_a = bus.o_clk;
        bus.i_test_en = 1'b0;
        #2 hi_b = bus.o_clk;
        total++;
        if (hi_a !== 4'hF || hi_b !== 4'hF) begin
            bad++; $display("FAIL override_drop_mid: got %h/%h required F/F", hi_a, hi_b);
        end
        @(negedge clk); #1;
        step();
        total++;
        if (hi_a !== 4'h0) begin bad++; $display("FAIL override_drop_next: got %h required 0", hi_a); end
        // Raising it mid-pulse must not create a partial pulse.
        @(posedge clk); model_update();
        #1 bus.i_test_en = 1'b1;
        #2 hi_b = bus.o_clk;
        total++;
        if (hi_b !== 4'h0) begin bad++; $display("FAIL override_raise_mid: got %h required 0", hi_b); end
        @(negedge clk); #1;
        step();
        total++;
        if (hi_a !== 4'hF) begin bad++; $display("FAIL override_raise_next: got %h required F", hi_a); end
        bus.i_test_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_run();
        bus.i_en = '1; bus.i_busy = '1;
        step(); step();
        bus.i_busy = 4'b0101;
        step(); step();
        rst = 1'b1;
        step();
        total++;
        if (hi_a !== 4'hF || bus.o_clk_on !== 4'h0 || bus.o_active_cnt !== 3'd0) begin
            bad++; $display("FAIL rst_mid_edge: clk=%h clk_on=%h cnt=%0d required F/0/0",
                            hi_a, bus.o_clk_on, bus.o_active_cnt);
        end
        rst = 1'b0; bus.i_busy = 4'b0111;
        step();
        total++;
        if (hi_a !== 4'h0 || hi_b !== 4'h0 || lo !== 4'h0) begin
            bad++; $display("FAIL rst_mid_stop: got %h/%h/%h required 0", hi_a, hi_b, lo);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            total++;
            if (bus.o_sleep[3] !== (i == 5) || bus.o_sleep !== m_sl()) begin
                bad++; $display("FAIL rst_mid_idle_%0d: got %h required %h", i, bus.o_sleep, m_sl());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                bus.i_en[c]   = ($urandom_range(0, 19) != 0);
                bus.i_busy[c] = ($urandom_range(0, 9) < 3);
            end
            bus.i_test_en = ($urandom_range(0, 15) == 0);
            step();
            total++;
            if (bus.o_clk_on !== m_on() || bus.o_sleep !== m_sl() || bus.o_active_cnt !== m_cnt()) begin
                bad++; $display("FAIL rand_status_%0d: clk_on=%h sleep=%h cnt=%0d required %h/%h/%0d",
                                i, bus.o_clk_on, bus.o_sleep, bus.o_active_cnt, m_on(), m_sl(), m_cnt());
            end
            total++;
            if (hi_a !== exp_gate || hi_b !== exp_gate || lo !== 4'h0) begin
                bad++; $display("FAIL rand_clk_%0d: hi=%h/%h lo=%h required %h/%h/0",
                                i, hi_a, hi_b, lo, exp_gate, exp_gate);
            end
        end
        rst = 1'b0; bus.i_test_en = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_en[c] = 0; m_sleep[c] = 0; m_idle[c] = 0;
        end
        test_reset();
        test_enable_disable();
        test_idle_gating();
        test_priority();
        test_override();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
